// File: rtl/irq_decoder.sv
// Interrupt decoder: captures request lines into a pending register, masks them and
// presents the lowest enabled source until acknowledged. Define IRQ_DECODER_EDGE_EN for edge capture.
module irq_decoder #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   src,
  input  logic           mask_we,
  input  logic [N-1:0]   mask_wdata,
  input  logic           ack,
  output logic           irq,
  output logic [IDW-1:0] irq_id,
  output logic [N-1:0]   pending
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           irq_q, irq_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;

  logic [N-1:0]   capture;
  logic [N-1:0]   effective;
  logic [N-1:0]   ack_clear;
  logic [IDW-1:0] lowest_id;

`ifdef IRQ_DECODER_EDGE_EN
  logic [N-1:0] src_dly_q, src_dly_d;

  // Only a low-to-high transition counts, so a held line yields a single event.
  always_comb begin
    src_dly_d = src;
    capture   = src & ~src_dly_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_dly_q <= '0;
    end else begin
      src_dly_q <= src_dly_d;
    end
  end
`else
  always_comb begin
    capture = src;
  end
`endif

  assign effective = pending_q & mask_q;

  // Index 0 wins: scan downwards so the lowest set bit is the last assignment.
  always_comb begin
    lowest_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (effective[i]) begin
        lowest_id = IDW'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    irq_id_d  = irq_id_q;
    ack_clear = '0;
    case (state_q)
      IDLE: begin
        if (|effective) begin
          irq_id_d = lowest_id;
          irq_d    = 1'b1;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          ack_clear[irq_id_q] = 1'b1;
          irq_d               = 1'b0;
          state_d             = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A capture on the acknowledge edge re-sets the bit, so no event is lost.
  always_comb begin
    pending_d = (pending_q & ~ack_clear) | capture;
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '1;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_decoder.sv
// Randomized and directed bench for irq_decoder against a service-level reference model.
// Honours IRQ_DECODER_EDGE_EN the same way the design does.
module tb_irq_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       ack;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int n_checks   = 0;
  int n_failures = 0;
  int step_no    = 0;

  bit [7:0] m_pend;
  bit [7:0] m_mask;
  bit [7:0] m_prev_src;
  bit       m_serving;
  int       m_cooldown;
  int       m_id;
  int       m_services;

  int       dut_services;
  logic     last_irq;

  irq_decoder #(.N(8), .IDW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .irq        (irq),
    .irq_id     (irq_id),
    .pending    (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_failures++;
      $display("[TB] FAIL %s at step %0d: got %0h, expected %0h", tag, step_no, observed, expected);
    end
  endtask

  function automatic int lowestSet(input bit [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Reference: one service = present lowest enabled source, wait for ack, then one quiet cycle.
  task automatic modelStep(input bit r, input bit [7:0] s, input bit we, input bit [7:0] wd, input bit a);
    bit [7:0] cap;
    bit [7:0] eff;
    if (r) begin
      m_pend     = 8'h00;
      m_mask     = 8'hFF;
      m_prev_src = 8'h00;
      m_serving  = 1'b0;
      m_cooldown = 0;
      m_id       = 0;
      return;
    end
`ifdef IRQ_DECODER_EDGE_EN
    cap = s & ~m_prev_src;
`else
    cap = s;
`endif
    eff = m_pend & m_mask;
    if (m_serving) begin
      if (a) begin
        m_pend     = m_pend & ~(8'd1 << m_id);
        m_serving  = 1'b0;
        m_cooldown = 1;
        m_services++;
      end
    end else if (m_cooldown > 0) begin
      m_cooldown--;
    end else if (eff != 8'h00) begin
      m_id      = lowestSet(eff);
      m_serving = 1'b1;
    end
    m_pend     = m_pend | cap;
    if (we) m_mask = wd;
    m_prev_src = s;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] s, input logic we,
                               input logic [7:0] wd, input logic a);
    @(negedge clk);
    rst        = r;
    src        = s;
    mask_we    = we;
    mask_wdata = wd;
    ack        = a;
    @(posedge clk);
    step_no++;
    if (a && last_irq && !r) dut_services++;
    modelStep(r, s, we, wd, a);
    #1;
    checkOutput("irq", {31'd0, irq}, {31'd0, m_serving});
    checkOutput("irq_id", {29'd0, irq_id}, m_id);
    checkOutput("pending", {24'd0, pending}, {24'd0, m_pend});
    last_irq = irq;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic ackStep();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    src          = 8'h00;
    mask_we      = 1'b0;
    mask_wdata   = 8'h00;
    ack          = 1'b0;
    last_irq     = 1'b0;
    m_services   = 0;
    dut_services = 0;
    modelStep(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(10);

    $display("[TB] single source");
    applyStimulus(1'b0, 8'h20, 1'b0, 8'h00, 1'b0);
    checkOutput("single_pending", {24'd0, pending}, 32'h20);
    idle(1);
    checkOutput("single_id", {29'd0, irq_id}, 32'd5);
    ackStep();
    checkOutput("single_ack_irq", {31'd0, irq}, 32'd0);
    idle(2);

    $display("[TB] priority and freeze");
    applyStimulus(1'b0, 8'h44, 1'b0, 8'h00, 1'b0);
    idle(1);
    checkOutput("prio_first", {29'd0, irq_id}, 32'd2);
    applyStimulus(1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
    idle(1);
    checkOutput("prio_frozen", {29'd0, irq_id}, 32'd2);
    ackStep();
    idle(2);
    checkOutput("prio_second", {29'd0, irq_id}, 32'd0);
    ackStep();
    idle(2);
    checkOutput("prio_third", {29'd0, irq_id}, 32'd6);
    ackStep();
    idle(2);

    $display("[TB] mask");
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hFE, 1'b0);
    applyStimulus(1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
    idle(3);
    checkOutput("mask_blocked", {31'd0, irq}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
    idle(1);
    checkOutput("mask_released", {31'd0, irq}, 32'd1);
    ackStep();
    idle(2);

    $display("[TB] capture/ack collision");
    applyStimulus(1'b0, 8'h08, 1'b0, 8'h00, 1'b0);
    idle(1);
    applyStimulus(1'b0, 8'h08, 1'b0, 8'h00, 1'b1);
    checkOutput("collide_pending", {24'd0, pending}, 32'h08);
    idle(2);
    checkOutput("collide_represent", {29'd0, irq_id}, 32'd3);
    ackStep();
    idle(2);

    $display("[TB] reset during presentation");
    applyStimulus(1'b0, 8'h10, 1'b0, 8'h00, 1'b0);
    idle(1);
    applyStimulus(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h10, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    ackStep();
    idle(2);

    $display("[TB] held source mode check");
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    m_services   = 0;
    dut_services = 0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h02, 1'b0, 8'h00, last_irq);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, last_irq);
`ifdef IRQ_DECODER_EDGE_EN
    checkOutput("mode_services", dut_services, 32'd1);
`else
    checkOutput("mode_services", dut_services, m_services);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      logic       r;
      logic [7:0] s;
      logic       we;
      logic [7:0] wd;
      logic       a;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 3) == 0) ? 8'($urandom() & $urandom()) : 8'h00;
      we = ($urandom_range(0, 15) == 0);
      wd = 8'($urandom());
      a  = last_irq ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      applyStimulus(r, s, we, wd, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/irq_decoder.md
# irq_decoder

Receiving end of the team's OR-combined interrupt path: captures up to N request lines into a pending register, masks them, drives one combined interrupt line, and reports which source fired. A consumer services the interrupt by acknowledging the reported ID. The block holds that ID stable until the acknowledge arrives, so the consumer always services a defined source. It sits between the peripheral request lines and the controlling state machine.

## Interface
- N, 8: number of request sources (2..32)
- IDW, 3: width of the ID field; must equal ceil(log2(N))
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- src  input  N  raw request lines, synchronous to clk
- mask_we  input  1  write enable for the mask register
- mask_wdata  input  N  new mask value; 1 = enabled
- ack  input  1  single-cycle acknowledge of the presented ID
- irq  output  1  combined interrupt, registered
- irq_id  output  IDW  ID of the source being presented, registered
- pending  output  N  raw pending register, unmasked

## Operation
- Capture:
  - pending[i] sets on any clock edge where the capture condition for src[i] holds (see Configuration).
  - A bit stays set until it is cleared by acknowledge or by reset.
  - Capture always happens regardless of mask.
- Mask:
  - mask resets to all-ones.
  - When mask_we=1, mask <= mask_wdata at that edge.
  - The effective set is pending & mask.
- FSM states: IDLE, PRESENT, GAP.
  - IDLE: if the effective set is nonzero, latch irq_id = lowest set index (index 0 has highest priority), set irq=1, and go to PRESENT.
  - PRESENT: irq=1 and irq_id are frozen, even if new or higher-priority bits arrive or the mask changes. If ack=1, clear pending[irq_id], set irq=0, and go to GAP.
  - GAP: irq=0 for exactly one cycle, then go to IDLE. This guarantees a deassertion between services.
- ack outside PRESENT is ignored, with no side effects.
- Simultaneous capture and acknowledge of the same bit: set wins, and the bit remains pending. A new event is never lost.
- If the presented source's mask bit is cleared while in PRESENT, presentation continues until ack.

## Timing
- Reset values: irq=0, irq_id=0, pending=0, mask=all-ones, state=IDLE. Reset has priority over every other input.
- Latency, capture: src event sampled at edge t causes pending[i]=1 after edge t.
- Latency, presentation: irq=1 with a valid irq_id after edge t+1, provided the FSM is in IDLE.
- Latency, acknowledge: ack sampled at edge a causes irq=0 and the pending bit to clear after edge a.
- Next presentation: the earliest possible is after edge a+2 (GAP at a+1).
- Throughput: at most one service per 3 cycles with back-to-back acks.
- Reset mid-PRESENT: all state clears. Any src level still high is re-captured according to the capture mode after reset deasserts.

## Configuration
- Macro: IRQ_DECODER_EDGE_EN.
- Defined: edge capture. The block keeps a registered copy src_d, reset to 0. The capture condition is src[i] & ~src_d[i]. A held-high source generates one event only.
- Undefined: level capture. The capture condition is src[i]. A bit cleared by ack re-sets on the next edge while src[i] stays high.
- irq and irq_id timing are identical in both modes.

## Test plan
- Reset, then idle: with src=0 for 10 cycles, irq=0, irq_id=0 and pending=0 throughout; mask reads back as 8'hFF by effect.
- Single source:
  - Pulse src[5] for 1 cycle at edge t.
  - Required: pending=8'h20 after t; irq=1 and irq_id=5 after t+1.
  - ack at the next edge: irq=0 and pending=0.
- Priority and freeze:
  - src[6] and src[2] rise together: irq_id=2 first.
  - Then src[0] rises during PRESENT: irq_id stays 2 until ack.
  - Next services: irq_id=0, then irq_id=6, each preceded by a 1-cycle irq low.
- Mask:
  - Write mask=8'hFE, then pulse src[0]: irq stays 0 and pending[0]=1.
  - Write mask=8'hFF: irq=1 with irq_id=0 two edges later.
- Capture and acknowledge collision: src[3] event on the same edge as the ack of ID 3 leaves pending[3]=1, and irq_id=3 is re-presented after GAP.
- Mode check:
  - Hold src[1]=1 for 20 cycles and ack every presentation.
  - With IRQ_DECODER_EDGE_EN: exactly 1 service.
  - Without it: repeated services every 3 cycles.
